// File: rtl/toy_pack.sv
// Shared front-end widths and the branch predictor update packet type.
package toy_pack;

  localparam int ADDR_WIDTH       = 32;
  localparam int ALIGN_WIDTH      = 4;
  localparam int FETCH_DATA_WIDTH = 128;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pred_pc;
    logic                   taken;
    logic [ADDR_WIDTH-1:0]  tgt_pc;
    logic [ALIGN_WIDTH-1:0] offset;
    logic                   is_cext;
    logic                   carry;
  } bpu_pkg;

endpackage

// File: rtl/toy_fe_chgflw_gen.sv
// Front-end change-flow generator: turns backend mispredict reports into
// single-cycle BTB update packets (via a small FIFO) and PC-gen redirects,
// with a quiesce window after each mispredict to block wrong-path resolves.
module toy_fe_chgflw_gen
  import toy_pack::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int QUIESCE_CYC = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  resolve_vld,
  output logic                  resolve_rdy,
  input  bpu_pkg                resolve_pld,
  input  logic                  resolve_mispred,
  input  logic                  flush,
  output logic                  chgflw_vld_o,
  output bpu_pkg                chgflw_pld_o,
  output logic                  redirect_vld,
  output logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int QW = $clog2(QUIESCE_CYC + 1);

  typedef enum logic {
    IDLE,
    QUIESCE
  } state_t;

  state_t                state;
  logic [QW-1:0]         qcnt;
  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  bpu_pkg                mem [FIFO_DEPTH];
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] block_pc;
  logic [ADDR_WIDTH-1:0] next_pc;

  // The extra pointer MSB distinguishes a full queue from an empty one.
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign fifo_empty = (wr_ptr == rd_ptr);

  // Gating with rst_n keeps the producer stalled while reset is held.
  assign resolve_rdy = rst_n && (state == IDLE) && !fifo_full && !flush;

  // Only accepted mispredicts are queued; correct predictions are dropped.
  assign push = resolve_vld && resolve_rdy && resolve_mispred;

  // The BTB side never backpressures, so a valid head always pops.
  assign pop = !fifo_empty;

  assign chgflw_vld_o = !fifo_empty;
  assign chgflw_pld_o = fifo_empty ? '0 : mem[rd_ptr[PW-1:0]];

  // Fall-through is the next aligned fetch block; the add wraps at the top of memory.
  assign block_pc = {resolve_pld.pred_pc[ADDR_WIDTH-1:ALIGN_WIDTH], {ALIGN_WIDTH{1'b0}}};

  // Redirect target: actual branch target if taken, else the sequential block.
  always_comb begin
    next_pc = block_pc + ADDR_WIDTH'(FETCH_DATA_WIDTH / 8);
    if (resolve_pld.taken) next_pc = resolve_pld.tgt_pc;
  end

  // Queue storage; entries are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= resolve_pld;
  end

  // Queue pointers; flush empties the queue and wins over any push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // One-cycle redirect pulse per accepted mispredict; flush cancels it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_vld <= 1'b0;
      redirect_pc  <= '0;
    end else if (flush) begin
      redirect_vld <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      redirect_vld <= push;
      if (push) redirect_pc <= next_pc;
    end
  end

  // Quiesce FSM: after a mispredict, hold off new reports for QUIESCE_CYC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      qcnt  <= '0;
    end else if (flush) begin
      state <= IDLE;
      qcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            state <= QUIESCE;
            qcnt  <= QW'(QUIESCE_CYC);
          end
        end
        QUIESCE: begin
          qcnt <= qcnt - 1'b1;
          if (qcnt == QW'(1)) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          qcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toy_fe_chgflw_gen.sv
// Directed bench for the change-flow generator: redirect targets, packet
// contents, quiesce timing, the mispredict filter, flush and reset behaviour.
module tb_toy_fe_chgflw_gen;
  import toy_pack::*;

  logic                  clk;
  logic                  rst_n;
  logic                  resolve_vld;
  logic                  resolve_rdy;
  bpu_pkg                resolve_pld;
  logic                  resolve_mispred;
  logic                  flush;
  logic                  chgflw_vld_o;
  bpu_pkg                chgflw_pld_o;
  logic                  redirect_vld;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  int tests_run;
  int tests_failed;
  int pulses;

  bpu_pkg pld_a;
  bpu_pkg pld_b;

  toy_fe_chgflw_gen #(
    .FIFO_DEPTH (4),
    .QUIESCE_CYC(3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .resolve_vld    (resolve_vld),
    .resolve_rdy    (resolve_rdy),
    .resolve_pld    (resolve_pld),
    .resolve_mispred(resolve_mispred),
    .flush          (flush),
    .chgflw_vld_o   (chgflw_vld_o),
    .chgflw_pld_o   (chgflw_pld_o),
    .redirect_vld   (redirect_vld),
    .redirect_pc    (redirect_pc)
  );

  // 10 ns free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bpu_pkg makePld(input logic [31:0] pc, input logic tk,
                                     input logic [31:0] tgt, input logic [3:0] off,
                                     input logic cext, input logic cy);
    bpu_pkg p;
    p.pred_pc = pc;
    p.taken   = tk;
    p.tgt_pc  = tgt;
    p.offset  = off;
    p.is_cext = cext;
    p.carry   = cy;
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic mis, input bpu_pkg pld,
                               input logic fl);
    resolve_vld     = vld;
    resolve_mispred = mis;
    resolve_pld     = pld;
    flush           = fl;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    pulses       = 0;
    rst_n        = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 1'b0);

    #3;
    checkOutput("reset_rdy",      resolve_rdy,  0);
    checkOutput("reset_chgflw",   chgflw_vld_o, 0);
    checkOutput("reset_pld",      chgflw_pld_o, 0);
    checkOutput("reset_redirect", redirect_vld, 0);
    checkOutput("reset_pc",       redirect_pc,  0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Not-taken mispredict: redirect to the next 16-byte block.
    cyc();
    pld_a = makePld(32'h0000_1004, 1'b0, 32'h0000_5554, 4'h4, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, pld_a, 1'b0);
    #1;
    checkOutput("nt_rdy_accept", resolve_rdy, 1);
    cyc();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("nt_redirect_vld", redirect_vld, 1);
    checkOutput("nt_redirect_pc",  redirect_pc,  32'h0000_1010);
    checkOutput("nt_chgflw_vld",   chgflw_vld_o, 1);
    checkOutput("nt_chgflw_taken", chgflw_pld_o.taken, 0);
    checkOutput("nt_rdy_q1",       resolve_rdy,  0);
    cyc();
    checkOutput("nt_rdy_q2",       resolve_rdy,  0);
    checkOutput("nt_chgflw_once",  chgflw_vld_o, 0);
    checkOutput("nt_redirect_once", redirect_vld, 0);
    cyc();
    checkOutput("nt_rdy_q3",       resolve_rdy,  0);
    cyc();
    checkOutput("nt_rdy_back",     resolve_rdy,  1);

    // Taken mispredict: redirect to target, packet is the report verbatim.
    cyc();
    pld_b = makePld(32'h0000_3000, 1'b1, 32'h0000_2000, 4'hC, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, pld_b, 1'b0);
    #1;
    checkOutput("tk_rdy_accept", resolve_rdy, 1);
    cyc();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("tk_redirect_vld", redirect_vld, 1);
    checkOutput("tk_redirect_pc",  redirect_pc,  32'h0000_2000);
    checkOutput("tk_chgflw_vld",   chgflw_vld_o, 1);
    checkOutput("tk_chgflw_pld",   chgflw_pld_o, pld_b);
    cyc();
    cyc();
    cyc();
    checkOutput("tk_rdy_back", resolve_rdy, 1);

    // Correct predictions are consumed without any side effect.
    for (int i = 0; i < 5; i++) begin
      cyc();
      applyStimulus(1'b1, 1'b0,
                    makePld(32'h0000_0100 + 32'(i * 4), i[0], 32'h0000_0800, 4'(i), 1'b0, 1'b0),
                    1'b0);
      #1;
      checkOutput("good_rdy", resolve_rdy, 1);
      if (chgflw_vld_o) pulses++;
      if (redirect_vld) pulses++;
    end
    cyc();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    if (chgflw_vld_o) pulses++;
    if (redirect_vld) pulses++;
    cyc();
    if (chgflw_vld_o) pulses++;
    if (redirect_vld) pulses++;
    checkOutput("good_no_pulses", pulses, 0);

    // Flush coincident with the redirect pulse.
    cyc();
    applyStimulus(1'b1, 1'b1, makePld(32'h0000_4000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0), 1'b0);
    #1;
    checkOutput("fl_rdy_accept", resolve_rdy, 1);
    cyc();
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("fl_redirect_vld", redirect_vld, 1);
    checkOutput("fl_redirect_pc",  redirect_pc,  32'h0000_4010);
    checkOutput("fl_chgflw_vld",   chgflw_vld_o, 1);
    checkOutput("fl_rdy_during",   resolve_rdy,  0);
    cyc();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("fl_chgflw_after",   chgflw_vld_o, 0);
    checkOutput("fl_redirect_after", redirect_vld, 0);
    checkOutput("fl_rdy_after",      resolve_rdy,  1);

    // Flush blocks an offered mispredict.
    cyc();
    applyStimulus(1'b1, 1'b1, makePld(32'h0000_6000, 1'b1, 32'h0000_7000, 4'h0, 1'b0, 1'b0), 1'b1);
    #1;
    checkOutput("fb_rdy", resolve_rdy, 0);
    cyc();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("fb_chgflw",   chgflw_vld_o, 0);
    checkOutput("fb_redirect", redirect_vld, 0);
    checkOutput("fb_rdy_next", resolve_rdy,  1);

    // Fall-through from the last block wraps to address zero.
    cyc();
    applyStimulus(1'b1, 1'b1, makePld(32'hFFFF_FFF8, 1'b0, 32'h0000_1234, 4'h8, 1'b0, 1'b0), 1'b0);
    #1;
    checkOutput("wr_rdy_accept", resolve_rdy, 1);
    cyc();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("wr_redirect_vld", redirect_vld, 1);
    checkOutput("wr_redirect_pc",  redirect_pc,  32'h0000_0000);
    cyc();
    cyc();
    cyc();
    checkOutput("wr_rdy_back", resolve_rdy, 1);

    // Reset asserted while quiescing clears all outputs at once.
    cyc();
    applyStimulus(1'b1, 1'b1, makePld(32'h0000_8000, 1'b1, 32'h0000_2468, 4'h2, 1'b1, 1'b1), 1'b0);
    #1;
    checkOutput("rs_rdy_accept", resolve_rdy, 1);
    cyc();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("rs_pre_redirect", redirect_pc, 32'h0000_2468);
    checkOutput("rs_pre_chgflw",   chgflw_vld_o, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rs_redirect_vld", redirect_vld, 0);
    checkOutput("rs_redirect_pc",  redirect_pc,  0);
    checkOutput("rs_chgflw_vld",   chgflw_vld_o, 0);
    checkOutput("rs_chgflw_pld",   chgflw_pld_o, 0);
    checkOutput("rs_rdy",          resolve_rdy,  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checkOutput("rs_rdy_after",      resolve_rdy,  1);
    checkOutput("rs_chgflw_after",   chgflw_vld_o, 0);
    checkOutput("rs_redirect_after", redirect_vld, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
